// File: rtl/led_frame_streamer.sv
// One-wire LED frame streamer: fetches NUM_LEDS GRB words from a bank of a
// registered ROM and serialises them MSB first as pulse-width coded bits.
module led_frame_streamer #(
  parameter int NUM_LEDS   = 20,
  parameter int BANK0_BASE = 0,
  parameter int BANK1_BASE = 100,
  parameter int T0H        = 20,
  parameter int T1H        = 40,
  parameter int T_BIT      = 63,
  parameter int T_RESET    = 3000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_bank,
  output logic [7:0]  o_rom_addr,
  output logic        o_rom_ren,
  input  logic [23:0] i_rom_data,
  output logic        o_dout,
  output logic        o_busy,
  output logic        o_done
);

  localparam int CMAX = (T_BIT > T_RESET) ? T_BIT : T_RESET;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [CW-1:0] T0H_END   = CW'(T0H - 1);
  localparam logic [CW-1:0] T1H_END   = CW'(T1H - 1);
  localparam logic [CW-1:0] TBIT_END  = CW'(T_BIT - 1);
  localparam logic [CW-1:0] TRST_END  = CW'(T_RESET - 1);
  localparam logic [CW-1:0] TRST_DONE = CW'(T_RESET - 2);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, SEND_HIGH, SEND_LOW, LATCH
  } state_t;

  state_t         state;
  logic           bank;
  logic [IW-1:0]  idx;
  logic [23:0]    shreg;
  logic [4:0]     bitcnt;
  logic [CW-1:0]  timer;

  function automatic logic [7:0] word_addr(input logic sel, input logic [IW-1:0] led);
    return 8'((sel ? BANK1_BASE : BANK0_BASE) + int'(led));
  endfunction

  // Frame sequencer; all outputs are registered alongside the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      bank       <= 1'b0;
      idx        <= '0;
      shreg      <= 24'h000000;
      bitcnt     <= 5'd0;
      timer      <= '0;
      o_rom_addr <= 8'h00;
      o_rom_ren  <= 1'b0;
      o_dout     <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_dout <= 1'b0;
          o_done <= 1'b0;
          if (i_start) begin
            bank       <= i_bank;
            idx        <= '0;
            o_busy     <= 1'b1;
            o_rom_ren  <= 1'b1;
            o_rom_addr <= word_addr(i_bank, '0);
            state      <= FETCH;
          end else begin
            o_busy <= 1'b0;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          // ROM data registered from the FETCH-cycle address is valid now.
          shreg      <= i_rom_data;
          bitcnt     <= 5'd0;
          timer      <= '0;
          o_rom_ren  <= 1'b0;
          o_rom_addr <= 8'h00;
          o_dout     <= 1'b1;
          state      <= SEND_HIGH;
        end
        SEND_HIGH: begin
          timer <= timer + CW'(1);
          if (timer == (shreg[23] ? T1H_END : T0H_END)) begin
            o_dout <= 1'b0;
            state  <= SEND_LOW;
          end else begin
            o_dout <= 1'b1;
          end
        end
        SEND_LOW: begin
          o_dout <= 1'b0;
          if (timer != TBIT_END) begin
            timer <= timer + CW'(1);
          end else if (bitcnt != 5'd23) begin
            shreg  <= {shreg[22:0], 1'b0};
            bitcnt <= bitcnt + 5'd1;
            timer  <= '0;
            o_dout <= 1'b1;
            state  <= SEND_HIGH;
          end else if (idx != LAST_IDX) begin
            idx        <= idx + IW'(1);
            o_rom_ren  <= 1'b1;
            o_rom_addr <= word_addr(bank, idx + IW'(1));
            state      <= FETCH;
          end else begin
            timer  <= '0;
            o_done <= (T_RESET == 1);
            state  <= LATCH;
          end
        end
        LATCH: begin
          o_dout <= 1'b0;
          if (timer == TRST_END) begin
            timer  <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            state  <= IDLE;
          end else begin
            timer  <= timer + CW'(1);
            o_done <= (timer == TRST_DONE);
          end
        end
        default: begin
          state      <= IDLE;
          o_rom_ren  <= 1'b0;
          o_rom_addr <= 8'h00;
          o_dout     <= 1'b0;
          o_busy     <= 1'b0;
          o_done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
